// File: rtl/arith_pkg.sv
// Shared arithmetic-unit package: control FSM state encoding and a
// constant clog2 helper used to size iteration counters.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Number of bits needed to represent values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/shift_register_left.sv
// Left-shifting register with parallel load, shift enable, serial input at
// the LSB and serial output from the MSB. The MSB leaves only through
// o_serial_out; o_lower exposes the remaining bits.
module shift_register_left #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_shift,
    input  logic             i_serial_in,
    output logic [WIDTH-2:0] o_lower,
    output logic             o_serial_out
);

    logic [WIDTH-1:0] r_data;

    // Load has priority over shift; shifting moves toward the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= {r_data[WIDTH-2:0], i_serial_in};
        end
    end

    assign o_lower      = r_data[WIDTH-2:0];
    assign o_serial_out = r_data[WIDTH-1];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider. The partial remainder A and the
// dividend/quotient register Q shift left together one bit per cycle; each
// cycle a trial subtraction of the divisor decides the next quotient bit.
module restoring_divider
    import arith_pkg::*;
#(
    parameter int WORD_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WORD_LENGTH-1:0] dividend,
    input  logic [WORD_LENGTH-1:0] divisor,
    output logic                   ready,
    output logic                   done,
    output logic [WORD_LENGTH-1:0] quotient,
    output logic [WORD_LENGTH-1:0] remainder,
    output logic                   div_by_zero
);

    localparam int WL = WORD_LENGTH;
    localparam int CW = clog2(WL + 1);

    div_state_t r_state;
    div_state_t w_next_state;

    logic [WL:0]    r_a;
    logic [WL-1:0]  r_m;
    logic [CW-1:0]  r_cnt;
    logic [WL-1:0]  r_quotient;
    logic [WL-1:0]  r_remainder;
    logic           r_div_by_zero;

    logic [WL-2:0]  w_q_lower;
    logic           w_q_msb;
    logic [WL+1:0]  w_trial;
    logic           w_trial_ok;
    logic           w_accept;
    logic           w_calc;
    logic           w_last;
    logic           w_divisor_zero;

    assign w_divisor_zero = (divisor == '0);
    assign w_accept       = (r_state == IDLE) && start;
    assign w_calc         = (r_state == CALC);
    assign w_last         = w_calc && (r_cnt == CW'(1));

    // The full {A, Q-MSB} is kept in the trial so no shifted-out bit is lost;
    // a clear top bit means the shifted remainder covers the divisor.
    assign w_trial    = {r_a, w_q_msb} - {2'b00, r_m};
    assign w_trial_ok = ~w_trial[WL+1];

    shift_register_left #(
        .WIDTH(WL)
    ) u_q_reg (
        .clk         (clk),
        .rst_n       (reset),
        .i_load      (w_accept),
        .i_data      (dividend),
        .i_shift     (w_calc),
        .i_serial_in (w_trial_ok),
        .o_lower     (w_q_lower),
        .o_serial_out(w_q_msb)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; start is only honoured in IDLE.
    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_next_state = w_divisor_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_cnt == CW'(1)) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Partial remainder, divisor and iteration counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a   <= '0;
            r_m   <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= '0;
            r_m   <= divisor;
            r_cnt <= CW'(WL);
        end else if (w_calc) begin
            r_a   <= w_trial_ok ? w_trial[WL:0] : {r_a[WL-1:0], w_q_msb};
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Result registers load on the edge entering DONE so they are valid with done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else if (w_accept && w_divisor_zero) begin
            r_quotient    <= '1;
            r_remainder   <= dividend;
            r_div_by_zero <= 1'b1;
        end else if (w_last) begin
            r_quotient    <= {w_q_lower, w_trial_ok};
            r_remainder   <= w_trial_ok ? w_trial[WL-1:0] : {r_a[WL-2:0], w_q_msb};
            r_div_by_zero <= 1'b0;
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
